pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the fetch stage. It generalises the plain PC register with several additions:
- sequential increment with a configurable step;
- stall hold;
- prioritised redirect, branch, call and return sources;
- an internal circular return-address stack (RAS).

It drives the instruction-memory address and supplies the next-PC value to the fetch pipeline.

Parameters:
INST_ADDR_WIDTH, 16, width of PC and all address ports
PC_STEP, 1, increment added for sequential fetch, modulo 2^INST_ADDR_WIDTH
RESET_VECTOR, 0, PC value loaded on reset
RAS_DEPTH, 4, number of return-address entries (power of two, >=2)
RAS_FLUSH_ON_REDIRECT, 1, 1 = redirect empties the RAS; 0 = RAS preserved

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset
stall  in  1  hold PC and RAS this cycle
redirect_valid  in  1  exception/interrupt/mispredict redirect
redirect_target  in  INST_ADDR_WIDTH  redirect destination
branch_taken  in  1  taken branch or jump
call  in  1  call: jump to branch_target and push return address
ret  in  1  return: pop RAS and jump to popped address
branch_target  in  INST_ADDR_WIDTH  target for branch_taken and call
pc_out  out  INST_ADDR_WIDTH  current PC (registered)
pc_next  out  INST_ADDR_WIDTH  value pc_out takes at the next edge (combinational)
ras_empty  out  1  RAS holds no entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_overflow  out  1  sticky: a push overwrote the oldest entry
ret_underflow  out  1  one-cycle pulse: ret seen with RAS empty

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst=1:
  - pc_out=RESET_VECTOR;
  - RAS count=0, so ras_empty=1 and ras_full=0;
  - ras_overflow=0 and ret_underflow=0.
- Reset mid-operation discards all pending state; the first edge after release applies normal selection.
- pc_next selection, highest priority first:
  1. redirect_valid -> redirect_target.
  2. stall -> pc_out (hold).
  3. ret -> RAS top if non-empty, else pc_out+PC_STEP.
  4. call -> branch_target.
  5. branch_taken -> branch_target.
  6. otherwise pc_out+PC_STEP.
- Latency: pc_out <= pc_next on every rising edge. A redirect, branch, call or return is visible on pc_out exactly one cycle after assertion.
- Arithmetic: all additions truncate to INST_ADDR_WIDTH, so 0xFFFF+1 -> 0x0000 with no flag. Return address = pc_out+PC_STEP with the same wrap.
- RAS updates occur only when the selected source is call or ret:
  - Call: push the return address.
  - Call when full: overwrite the oldest entry (circular pointer), count stays RAS_DEPTH, set ras_overflow.
  - Ret when non-empty: pop.
  - Ret when empty: no pop; ret_underflow=1 for that cycle (registered, visible the next cycle for one cycle); PC falls through sequentially.
- Simultaneous events:
  - call+ret together: ret wins and the call is ignored (no push).
  - call+branch_taken together: treated as call.
  - stall+ret or stall+call: neither takes effect and the RAS is unchanged.
  - redirect+anything: redirect wins. The RAS is cleared if RAS_FLUSH_ON_REDIRECT=1 (count=0), otherwise unchanged. ras_overflow is not cleared by redirect.
- ras_overflow clears only on reset.
- ras_empty and ras_full are derived from the registered count and are never both 1.

Decomposition:
- Shared package (pc_pkg):
  - PC source select encoding: SRC_SEQ, SRC_HOLD, SRC_REDIRECT, SRC_BRANCH, SRC_CALL, SRC_RET;
  - pointer-width constant computed from RAS_DEPTH (clog2).
- Sub-module pc_ras:
  - contains the storage array, top pointer, count, push/pop/flush inputs, top/empty/full/overflow outputs;
  - has the same clk/rst convention as pc_unit.
- pc_unit contains the priority mux, adder and PC register.

Test Plan (INST_ADDR_WIDTH=16, PC_STEP=1, RESET_VECTOR=0x0100, RAS_DEPTH=4):
1. Assert rst asynchronously mid-cycle after 5 free-running cycles -> pc_out=0x0100 immediately. After release, pc_out steps 0x0101, 0x0102. ras_empty=1.
2. pc_out=0x0200, call with branch_target=0x0800 -> next pc_out=0x0800, ras_empty=0. Two cycles later, ret -> pc_out=0x0201, ras_empty=1.
3. Five nested calls from pc_out=0x0010,0x0020,0x0030,0x0040,0x0050 -> ras_full=1 after the 4th and ras_overflow=1 after the 5th. Four rets return 0x0051,0x0041,0x0031,0x0021. A 5th ret -> ret_underflow pulse, PC sequential.
4. stall held 3 cycles with branch_taken=1 and ret=1 -> pc_out constant and RAS count unchanged. Same cycle with redirect_valid=1, redirect_target=0x0F00 -> pc_out=0x0F00 and RAS count=0 (flush=1).
5. pc_out=0xFFFF, no control inputs -> pc_out=0x0000. call at 0xFFFF -> pushed return address 0x0000, and a later ret returns 0x0000.
6. call+ret together with RAS top 0x0333 -> pc_out=0x0333 and count decremented by one. call+branch_taken together -> a push occurs.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   - pc_src_e      : which source drives the next PC value
//   - ras_ptr_w()   : pointer width (clog2) derived from the RAS depth
//   - RAS_PTR_W_DEF : pointer width for the default four-entry RAS
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_SEQ      = 3'd0,
        SRC_HOLD     = 3'd1,
        SRC_REDIRECT = 3'd2,
        SRC_BRANCH   = 3'd3,
        SRC_CALL     = 3'd4,
        SRC_RET      = 3'd5
    } pc_src_e;

    // Pointer width for a return-address stack of the given depth.
    // The result is never below one, because the depth is at least two.
    function automatic int ras_ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    localparam int RAS_PTR_W_DEF = ras_ptr_w(4);

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, rst          : clock and asynchronous active-high reset
//   push, push_addr   : store push_addr as the new top. When the stack is full,
//                       the oldest entry is overwritten.
//   pop               : drop the top entry. This is ignored when the stack is empty.
//   flush             : discard all entries (count returns to zero)
//   top               : address held in the top entry
//   empty, full       : decoded from the registered entry count
//   overflow          : sticky flag, set when a push overwrites an entry; cleared only by reset
// flush takes priority over push, and push over pop. The PC unit never requests more than one at a time.
module pc_ras
    import pc_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop,
    input  logic              flush,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int PTR_W = ras_ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  top_ptr_r;
    logic [PTR_W:0]    count_r;
    logic              overflow_r;
    logic [PTR_W-1:0]  wr_ptr_s;
    logic              full_s;
    logic              empty_s;

    // The next push lands one slot above the top. When the stack is full, that slot holds the oldest entry.
    assign wr_ptr_s = top_ptr_r + PTR_ONE;
    assign full_s   = (count_r == CNT_FULL);
    assign empty_s  = (count_r == CNT_ZERO);

    // Stack storage, top pointer, entry count and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            top_ptr_r  <= '0;
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else if (flush) begin
            count_r <= CNT_ZERO;
        end else if (push) begin
            mem_r[wr_ptr_s] <= push_addr;
            top_ptr_r       <= wr_ptr_s;
            if (full_s) begin
                overflow_r <= 1'b1;
            end else begin
                count_r <= count_r + CNT_ONE;
            end
        end else if (pop && !empty_s) begin
            top_ptr_r <= top_ptr_r - PTR_ONE;
            count_r   <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign top      = mem_r[top_ptr_r];
    assign empty    = empty_s;
    assign full     = full_s;
    assign overflow = overflow_r;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with a return-address stack.
//   clk, rst          : clock and asynchronous active-high reset
//   stall             : hold the PC and the RAS
//   redirect_valid/_target      : highest-priority redirect
//   branch_taken, call, ret, branch_target : control-flow sources
//   pc_out            : registered current PC
//   pc_next           : combinational value that pc_out takes at the next edge
//   ras_empty/ras_full/ras_overflow : RAS status
//   ret_underflow     : one-cycle pulse following a ret issued with an empty RAS
module pc_unit
    import pc_pkg::*;
#(
    parameter int                         INST_ADDR_WIDTH       = 16,
    parameter int                         PC_STEP               = 1,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_VECTOR          = '0,
    parameter int                         RAS_DEPTH             = 4,
    parameter bit                         RAS_FLUSH_ON_REDIRECT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       redirect_valid,
    input  logic [INST_ADDR_WIDTH-1:0] redirect_target,
    input  logic                       branch_taken,
    input  logic                       call,
    input  logic                       ret,
    input  logic [INST_ADDR_WIDTH-1:0] branch_target,
    output logic [INST_ADDR_WIDTH-1:0] pc_out,
    output logic [INST_ADDR_WIDTH-1:0] pc_next,
    output logic                       ras_empty,
    output logic                       ras_full,
    output logic                       ras_overflow,
    output logic                       ret_underflow
);

    localparam logic [INST_ADDR_WIDTH-1:0] STEP = INST_ADDR_WIDTH'(PC_STEP);

    logic [INST_ADDR_WIDTH-1:0] pc_r;
    logic                       underflow_r;
    logic [INST_ADDR_WIDTH-1:0] pc_seq_s;
    logic [INST_ADDR_WIDTH-1:0] pc_next_s;
    logic [INST_ADDR_WIDTH-1:0] ras_top_s;
    logic                       ras_empty_s;
    logic                       ras_full_s;
    logic                       ras_overflow_s;
    logic                       push_s;
    logic                       pop_s;
    logic                       flush_s;
    logic                       underflow_s;
    pc_src_e                    src_s;

    // The sequential address wraps at the address width. It is also the return address pushed by a call.
    assign pc_seq_s = pc_r + STEP;

    // Priority select of the PC source. ret outranks call, and call outranks branch_taken.
    always_comb begin
        src_s = SRC_SEQ;
        if (redirect_valid) begin
            src_s = SRC_REDIRECT;
        end else if (stall) begin
            src_s = SRC_HOLD;
        end else if (ret) begin
            src_s = SRC_RET;
        end else if (call) begin
            src_s = SRC_CALL;
        end else if (branch_taken) begin
            src_s = SRC_BRANCH;
        end else begin
            src_s = SRC_SEQ;
        end
    end

    // Next-PC mux and RAS control decoded from the selected source.
    always_comb begin
        pc_next_s   = pc_seq_s;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        flush_s     = 1'b0;
        underflow_s = 1'b0;
        case (src_s)
            SRC_REDIRECT: begin
                pc_next_s = redirect_target;
                flush_s   = RAS_FLUSH_ON_REDIRECT;
            end
            SRC_HOLD: begin
                pc_next_s = pc_r;
            end
            SRC_RET: begin
                if (ras_empty_s) begin
                    // An empty stack falls through to sequential fetch and flags the underflow.
                    pc_next_s   = pc_seq_s;
                    underflow_s = 1'b1;
                end else begin
                    pc_next_s = ras_top_s;
                    pop_s     = 1'b1;
                end
            end
            SRC_CALL: begin
                pc_next_s = branch_target;
                push_s    = 1'b1;
            end
            SRC_BRANCH: begin
                pc_next_s = branch_target;
            end
            SRC_SEQ: begin
                pc_next_s = pc_seq_s;
            end
            default: begin
                pc_next_s = pc_seq_s;
            end
        endcase
    end

    // PC register and the registered underflow pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r        <= RESET_VECTOR;
            underflow_r <= 1'b0;
        end else begin
            pc_r        <= pc_next_s;
            underflow_r <= underflow_s;
        end
    end

    pc_ras #(
        .ADDR_W (INST_ADDR_WIDTH),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_addr (pc_seq_s),
        .pop       (pop_s),
        .flush     (flush_s),
        .top       (ras_top_s),
        .empty     (ras_empty_s),
        .full      (ras_full_s),
        .overflow  (ras_overflow_s)
    );

    assign pc_out        = pc_r;
    assign pc_next       = pc_next_s;
    assign ras_empty     = ras_empty_s;
    assign ras_full      = ras_full_s;
    assign ras_overflow  = ras_overflow_s;
    assign ret_underflow = underflow_r;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed test-plan steps followed by randomized cycles. The expected
// values come from a queue-based reference model of the PC and the return-address stack.
module tb_pc_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect_valid, branch_taken, call, ret;
    logic [15:0] redirect_target, branch_target;
    logic [15:0] pc_out, pc_next;
    logic        ras_empty, ras_full, ras_overflow, ret_underflow;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [15:0] m_pc;
    logic [15:0] m_ras[$];
    logic        m_ovf;
    logic        m_unf;

    pc_unit #(
        .INST_ADDR_WIDTH       (16),
        .PC_STEP               (1),
        .RESET_VECTOR          (16'h0100),
        .RAS_DEPTH             (DEPTH),
        .RAS_FLUSH_ON_REDIRECT (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .branch_taken    (branch_taken),
        .call            (call),
        .ret             (ret),
        .branch_target   (branch_target),
        .pc_out          (pc_out),
        .pc_next         (pc_next),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .ras_overflow    (ras_overflow),
        .ret_underflow   (ret_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0100;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Next PC, derived from the priority rules and the current model state.
    function automatic logic [15:0] model_next();
        if (redirect_valid) return redirect_target;
        if (stall) return m_pc;
        if (ret) return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : m_pc + 16'd1;
        if (call || branch_taken) return branch_target;
        return m_pc + 16'd1;
    endfunction

    // Advance the model by one clock edge.
    task automatic model_edge();
        logic [15:0] nxt;
        nxt   = model_next();
        m_unf = 1'b0;
        if (redirect_valid) begin
            m_ras.delete();
        end else if (stall) begin
            m_unf = 1'b0;
        end else if (ret) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
            else m_unf = 1'b1;
        end else if (call) begin
            m_ras.push_back(m_pc + 16'd1);
            if (m_ras.size() > DEPTH) begin
                void'(m_ras.pop_front());
                m_ovf = 1'b1;
            end
        end
        m_pc = nxt;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pc_out"}, pc_out, m_pc);
        chk({tag, ".empty"}, 16'(ras_empty), 16'(m_ras.size() == 0));
        chk({tag, ".full"}, 16'(ras_full), 16'(m_ras.size() == DEPTH));
        chk({tag, ".ovf"}, 16'(ras_overflow), 16'(m_ovf));
        chk({tag, ".unf"}, 16'(ret_underflow), 16'(m_unf));
    endtask

    // A cycle starts just after a rising edge: drive the inputs, check pc_next, clock, then check the state.
    task automatic cycle(input string tag, input logic rv, input logic [15:0] rt, input logic st,
                         input logic br, input logic ca, input logic re, input logic [15:0] bt);
        redirect_valid = rv; redirect_target = rt; stall = st;
        branch_taken = br; call = ca; ret = re; branch_target = bt;
        #1;
        chk({tag, ".pc_next"}, pc_next, model_next());
        @(posedge clk);
        model_edge();
        #1;
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic go(input string tag, input logic [15:0] a);
        cycle(tag, 1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_call(input string tag, input logic [15:0] bt);
        cycle(tag, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, bt);
    endtask

    task automatic do_ret(input string tag);
        cycle(tag, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0; redirect_valid = 1'b0; branch_taken = 1'b0; call = 1'b0; ret = 1'b0;
        redirect_target = 16'h0; branch_target = 16'h0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check_state("reset");

        // 1: asynchronous reset in the middle of a cycle
        for (int i = 0; i < 5; i++) idle("run");
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.pc_out", pc_out, 16'h0100);
        check_state("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle("post_rst1");
        chk("post_rst1.const", pc_out, 16'h0101);
        idle("post_rst2");
        chk("post_rst2.const", pc_out, 16'h0102);

        // 2: a call followed by its return
        go("to200", 16'h0200);
        do_call("call800", 16'h0800);
        chk("call800.const", pc_out, 16'h0800);
        idle("c_idle1");
        idle("c_idle2");
        do_ret("ret201");
        chk("ret201.const", pc_out, 16'h0201);

        // 3: nested calls, overflow, then underflow
        go("to10", 16'h0010);
        for (int i = 1; i <= 5; i++) do_call("nest", 16'((i + 1) * 16));
        chk("nest.ovf", 16'(ras_overflow), 16'h1);
        for (int i = 0; i < 4; i++) do_ret("unwind");
        chk("unwind.last", pc_out, 16'h0021);
        do_ret("underflow");
        chk("underflow.pulse", 16'(ret_underflow), 16'h1);
        idle("underflow_gone");

        // 4: stall hold, then a redirect during a stall
        do_call("pre_stall", 16'h0700);
        for (int i = 0; i < 3; i++) cycle("stall", 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0AAA);
        cycle("redir_stall", 1'b1, 16'h0F00, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0AAA);
        chk("redir_stall.const", pc_out, 16'h0F00);

        // 5: address wrap-around
        go("toFFFF", 16'hFFFF);
        idle("wrap");
        chk("wrap.const", pc_out, 16'h0000);
        go("toFFFF_b", 16'hFFFF);
        do_call("call_wrap", 16'h1234);
        idle("cw_idle");
        do_ret("ret_wrap");
        chk("ret_wrap.const", pc_out, 16'h0000);

        // 6: call and ret together, then call and branch together
        go("to332", 16'h0332);
        do_call("push333", 16'h0500);
        cycle("call_ret", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0900);
        chk("call_ret.const", pc_out, 16'h0333);
        cycle("call_br", 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0C00);
        do_ret("ret_cb");

        // Randomized cycles
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(15) == 0), 16'($urandom),
                  ($urandom_range(7) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(3) == 0), ($urandom_range(3) == 0), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
